// File: rtl/dp_ram_be_clr_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM with clear sequencer.
package ram_pkg;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned MAX_DW = 1024;
  localparam int unsigned MAX_NL = 128;

  // Lanes with be set come from new_w, the rest from old_w; callers cast to their own width.
  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_NL-1:0] be,
    input int unsigned       bw
  );
    logic [MAX_DW-1:0] mask;
    mask = '0;
    for (int unsigned b = 0; b < MAX_DW; b++) begin
      if ((b / bw) < MAX_NL) mask[b] = be[b / bw];
    end
    return (old_w & ~mask) | (new_w & mask);
  endfunction

endpackage

// File: rtl/dp_ram_be_clr_core.sv
// Plain storage: lane-enabled write, registered read-first read, no reset.
module ram_be_core #(
  parameter int unsigned DW    = 64,
  parameter int unsigned BW    = 8,
  parameter int unsigned DEPTH = 2880,
  parameter int unsigned AW    = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [DW-1:0]    wd,
  input  logic [DW/BW-1:0] wbe,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  output logic [DW-1:0]    rq
);

  localparam int unsigned NL = DW / BW;

  (* syn_ramstyle = "block_ram" *) logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NL; i++) begin
        if (wbe[i]) r_mem[wa][i*BW +: BW] <= wd[i*BW +: BW];
      end
    end
    if (re) r_q <= r_mem[ra];
  end

  assign rq = r_q;

endmodule

// File: rtl/dp_ram_be_clr.sv
// Dual-port byte-enable RAM wrapper: clear sweep FSM, range checks, collision bypass, output stage.
module dp_ram_be_clr
  import ram_pkg::*;
#(
  parameter int unsigned DW           = 64,
  parameter int unsigned BW           = 8,
  parameter int unsigned DEPTH        = 2880,
  parameter int unsigned RDW_MODE     = 0,
  parameter int unsigned OREG         = 0,
  parameter int unsigned CLR_ON_RESET = 1,
  localparam int unsigned NL          = DW / BW,
  localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [NL-1:0] wbe,
  input  logic [AW-1:0] ra,
  input  logic          re,
  output logic [DW-1:0] rd,
  output logic          rvalid,
  input  logic          clr,
  output logic          busy,
  output clr_state_e    dbg_state
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
  localparam rdw_mode_e     P_RDW   = (RDW_MODE != 0) ? RDW_NEW : RDW_OLD;
  localparam clr_state_e    P_RST_S = (CLR_ON_RESET != 0) ? CLEAR : IDLE;

  clr_state_e    r_state, w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic          w_busy, w_idle;
  logic          w_wa_in, w_ra_in, w_usr_wr, w_rd_acc, w_rd_mem, w_coll;
  logic          w_core_we;
  logic [AW-1:0] w_core_wa;
  logic [DW-1:0] w_core_wd, w_core_q, w_rd_s1;
  logic [NL-1:0] w_core_be;
  logic          r_v1, r_zero;
  logic [NL-1:0] r_byp_be;
  logic [DW-1:0] r_byp_wd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= P_RST_S;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clr) w_state_nxt = CLEAR;
      CLEAR:   if (r_cnt == LAST_A) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == CLEAR);
    w_idle = (r_state == IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     r_cnt <= '0;
    else if (w_busy) r_cnt <= (r_cnt == LAST_A) ? '0 : r_cnt + 1'b1;
  end

  always_comb begin
    w_wa_in  = ({1'b0, wa} < DEPTH_W);
    w_ra_in  = ({1'b0, ra} < DEPTH_W);
    w_usr_wr = w_idle & we & w_wa_in & (|wbe);
    w_rd_acc = w_idle & re;
    w_rd_mem = w_rd_acc & w_ra_in;
    w_coll   = (P_RDW == RDW_NEW) & w_usr_wr & w_rd_mem & (wa == ra);
  end

  // The sweep owns the write port outright; user writes are already gated off while busy.
  always_comb begin
    w_core_we = w_busy | w_usr_wr;
    w_core_wa = w_busy ? r_cnt : wa;
    w_core_wd = w_busy ? '0 : wd;
    w_core_be = w_busy ? '1 : wbe;
  end

  ram_be_core #(
    .DW    (DW),
    .BW    (BW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk (clk),
    .we  (w_core_we),
    .wa  (w_core_wa),
    .wd  (w_core_wd),
    .wbe (w_core_be),
    .re  (w_rd_mem),
    .ra  (ra),
    .rq  (w_core_q)
  );

  // r_zero starts high so rd reads 0 until the first accepted read; out-of-range reads set it too.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v1     <= 1'b0;
      r_zero   <= 1'b1;
      r_byp_be <= '0;
      r_byp_wd <= '0;
    end else begin
      r_v1 <= w_rd_acc;
      if (w_rd_acc) begin
        r_zero   <= ~w_ra_in;
        r_byp_be <= w_coll ? wbe : '0;
        r_byp_wd <= wd;
      end
    end
  end

  assign w_rd_s1 = r_zero ? '0
                 : DW'(lane_merge(MAX_DW'(w_core_q), MAX_DW'(r_byp_wd), MAX_NL'(r_byp_be), BW));

  generate
    if (OREG != 0) begin : g_oreg
      logic [DW-1:0] r_rd_q;
      logic          r_v2;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_rd_q <= '0;
          r_v2   <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_rd_q <= w_rd_s1;
        end
      end
      assign rd     = r_rd_q;
      assign rvalid = r_v2;
    end else begin : g_noreg
      assign rd     = w_rd_s1;
      assign rvalid = r_v1;
    end
  endgenerate

  assign busy      = w_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dp_ram_be_clr.sv
// Randomised scoreboard bench for dp_ram_be_clr across three parameter sets sharing one stimulus stream.
module tb_dp_ram_be_clr;
  import ram_pkg::*;

  localparam int NI = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn = 1'b1;
  logic        we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [3:0]  wa = '0, ra = '0, wbe = '0;
  logic [31:0] wd = '0;

  logic [31:0] rd     [NI];
  logic        rvalid [NI];
  logic        busy   [NI];
  clr_state_e  dbg    [NI];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance k parameters, kept in step with the instantiations below
  int dep  [NI] = '{16, 16, 12};
  int oreg [NI] = '{0, 1, 0};
  int mode [NI] = '{0, 1, 1};

  dp_ram_be_clr #(.DW(32), .BW(8), .DEPTH(16), .RDW_MODE(0), .OREG(0), .CLR_ON_RESET(1)) u_dut0 (
    .clk(clk), .resetn(resetn), .wd(wd), .wa(wa), .we(we), .wbe(wbe), .ra(ra), .re(re),
    .rd(rd[0]), .rvalid(rvalid[0]), .clr(clr), .busy(busy[0]), .dbg_state(dbg[0]));

  dp_ram_be_clr #(.DW(32), .BW(8), .DEPTH(16), .RDW_MODE(1), .OREG(1), .CLR_ON_RESET(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .wd(wd), .wa(wa), .we(we), .wbe(wbe), .ra(ra), .re(re),
    .rd(rd[1]), .rvalid(rvalid[1]), .clr(clr), .busy(busy[1]), .dbg_state(dbg[1]));

  dp_ram_be_clr #(.DW(32), .BW(8), .DEPTH(12), .RDW_MODE(1), .OREG(0), .CLR_ON_RESET(1)) u_dut2 (
    .clk(clk), .resetn(resetn), .wd(wd), .wa(wa), .we(we), .wbe(wbe), .ra(ra), .re(re),
    .rd(rd[2]), .rvalid(rvalid[2]), .clr(clr), .busy(busy[2]), .dbg_state(dbg[2]));

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] mem [NI][16];
  int          clear_left [NI];
  logic [31:0] last_rd [NI];
  logic [63:0] exp_q [NI][$];   // {due cycle, data}

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @cyc %0d: got %0h, expected %0h", name, k, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int l = 0; l < 4; l++) if (be[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit w_en, input logic [3:0] w_a, input logic [31:0] w_d,
                      input logic [3:0] w_be, input bit r_en, input logic [3:0] r_a, input bit c);
    logic [31:0] e;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("busy", k, 64'(busy[k]), (clear_left[k] > 0) ? 64'd1 : 64'd0);
      check("state", k, 64'(dbg[k]), (clear_left[k] > 0) ? 64'(CLEAR) : 64'(IDLE));
    end
    resetn = ~rst; we = w_en; wa = w_a; wd = w_d; wbe = w_be; re = r_en; ra = r_a; clr = c;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        clear_left[k] = dep[k];
        exp_q[k].delete();
        last_rd[k] = '0;
      end else if (clear_left[k] > 0) begin
        clear_left[k]--;
      end else begin
        if (r_en) begin
          if (int'(r_a) >= dep[k])                        e = '0;
          else if (w_en && w_a == r_a && mode[k] == 1)    e = apply_be(mem[k][r_a], w_d, w_be);
          else                                            e = mem[k][r_a];
          exp_q[k].push_back({32'(cyc + 1 + oreg[k]), e});
        end
        if (w_en && int'(w_a) < dep[k]) mem[k][w_a] = apply_be(mem[k][w_a], w_d, w_be);
        if (c) begin
          clear_left[k] = dep[k];
          for (int i = 0; i < 16; i++) mem[k][i] = '0;
        end
      end
    end
  endtask

  task automatic idle_step();
    step(0, 0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 0);
  endtask

  task automatic rand_step(input bit c);
    logic [3:0] a_w, a_r;
    a_w = 4'($urandom_range(0, 15));
    a_r = ($urandom_range(0, 3) == 0) ? a_w : 4'($urandom_range(0, 15));
    step(0, 1'($urandom_range(0, 1)), a_w, $urandom, 4'($urandom_range(0, 15)),
         1'($urandom_range(0, 1)), a_r, c);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) step(0, 0, 4'd0, 32'd0, 4'd0, 1, 4'(a), 0);
  endtask

  // Counts busy cycles seen from the next negedge on; optional clr re-request at step clr_at.
  task automatic measure(input string name, input bit traffic, input int clr_at);
    int cnt [NI];
    for (int k = 0; k < NI; k++) cnt[k] = 0;
    for (int i = 0; i < 40; i++) begin
      if (traffic) rand_step(i == clr_at);
      else         step(0, 0, 4'd0, 32'd0, 4'd0, 0, 4'd0, i == clr_at);
      for (int k = 0; k < NI; k++) if (busy[k]) cnt[k]++;
    end
    for (int k = 0; k < NI; k++) check(name, k, 64'(cnt[k]), 64'(dep[k]));
  endtask

  // ---------------- monitor ----------------
  always begin : monitor
    logic [63:0] fr;
    @(posedge clk);
    #2;
    for (int k = 0; k < NI; k++) begin
      if (rvalid[k] === 1'b1) begin
        if (exp_q[k].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rvalid_spurious inst%0d @cyc %0d: got rvalid=1, expected 0", k, cyc);
        end else begin
          fr = exp_q[k].pop_front();
          check("rd_latency", k, 64'(cyc), 64'(fr[63:32]));
          check("rd_data", k, 64'(rd[k]), 64'(fr[31:0]));
          last_rd[k] = fr[31:0];
        end
      end else begin
        if (exp_q[k].size() > 0 && int'(exp_q[k][0][63:32]) <= cyc) begin
          check("rvalid_missing", k, 64'(rvalid[k]), 64'd1);
          void'(exp_q[k].pop_front());
        end
        check("rd_hold", k, 64'(rd[k]), 64'(last_rd[k]));
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int k = 0; k < NI; k++) begin
      clear_left[k] = dep[k];
      last_rd[k] = '0;
      for (int i = 0; i < 16; i++) mem[k][i] = '0;
    end
    #1 resetn = 1'b0;
    repeat (3) step(1, 0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 0);

    // power-on sweep, user traffic dropped while busy
    measure("sweep_por", 1, -1);
    repeat (4) idle_step();
    for (int k = 0; k < NI; k++) for (int i = 0; i < 16; i++) mem[k][i] = (int'(i) < dep[k]) ? mem[k][i] : '0;
    read_all();

    // partial lane write and collision cases
    step(0, 1, 4'd3, 32'hAABB_CCDD, 4'b0101, 0, 4'd0, 0);
    step(0, 0, 4'd0, 32'd0, 4'd0, 1, 4'd3, 0);
    step(0, 1, 4'd5, 32'h1122_3344, 4'b1111, 0, 4'd0, 0);
    step(0, 1, 4'd5, 32'hFFFF_FFFF, 4'b1100, 1, 4'd5, 0);
    step(0, 1, 4'd6, 32'h5555_5555, 4'b0000, 1, 4'd5, 0);
    step(0, 0, 4'd0, 32'd0, 4'd0, 1, 4'd6, 0);

    // out-of-range on the 12-deep instance
    step(0, 1, 4'd13, 32'hDEAD_BEEF, 4'b1111, 1, 4'd14, 0);
    step(0, 1, 4'd11, 32'hCAFE_F00D, 4'b1111, 1, 4'd13, 0);
    step(0, 0, 4'd0, 32'd0, 4'd0, 1, 4'd11, 0);

    repeat (300) rand_step($urandom_range(0, 39) == 0);
    repeat (20) idle_step();
    read_all();

    // clr with same-cycle access, then traffic and a second clr mid-sweep
    step(0, 1, 4'd2, 32'h0BAD_0BAD, 4'b1111, 1, 4'd2, 1);
    measure("sweep_clr", 1, 4);
    repeat (4) idle_step();
    read_all();

    // reset mid-sweep restarts from address 0
    for (int i = 0; i < 8; i++) step(0, 1, 4'(i), $urandom, 4'b1111, 0, 4'd0, 0);
    step(0, 0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 1);
    repeat (6) idle_step();
    repeat (2) step(1, 0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 0);
    measure("sweep_after_reset", 0, -1);
    repeat (4) idle_step();
    read_all();

    repeat (100) rand_step(1'b0);
    read_all();
    repeat (6) idle_step();
    for (int k = 0; k < NI; k++) check("queue_drained", k, 64'(exp_q[k].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
